srb_mrd: RTL and testbench
==========================

Name: srb_mrd

Overview:
- Parametrised successor to the single-read store result buffer, with SRB_DEPTH entries of DATA_WIDTH bits.
- Entries are allocated in order through a write handshake. Allocated entries are read by index over NUM_RD independent read channels.
- Each read channel has its own valid/ready request and a registered valid/ready response. A read frees the entry. Ring space is reclaimed in order from the bottom (oldest) pointer.
- Sits between the producer that deposits results and up to NUM_RD consumers that retrieve them by handle.

Parameters:
- DATA_WIDTH, 32, width of each entry.
- SRB_DEPTH, 8, entry count; power of two, at least 2.
- NUM_RD, 2, number of read channels, 1..4.
- IDX_W, $clog2(SRB_DEPTH), index width; derived, not to be overridden.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- w_req_valid  in  1  write request.
- w_req_ready  out  1  write accepted when valid&ready.
- w_req_data  in  DATA_WIDTH  write data.
- w_rsp_idx  out  IDX_W  index allocated by the current write (equals top pointer).
- r_req_valid  in  NUM_RD  per-channel read request.
- r_req_idx  in  NUM_RD*IDX_W  per-channel index; channel c uses bits [c*IDX_W +: IDX_W].
- r_req_ready  out  NUM_RD  per-channel request accept.
- r_rsp_valid  out  NUM_RD  per-channel response valid.
- r_rsp_data  out  NUM_RD*DATA_WIDTH  per-channel response data.
- r_rsp_err  out  NUM_RD  response targeted an invalid entry; data is zero.
- r_rsp_ready  in  NUM_RD  per-channel response accept.
- entry_valid  out  SRB_DEPTH  per-entry occupied flag.
- bottom_id  out  IDX_W  oldest allocated (unreclaimed) slot.

Behaviour:
- Reset: one clock and one reset. rst_n low at a posedge clears:
  - top and bottom pointers, and the wrap bit;
  - entry_valid, r_rsp_valid, r_rsp_err, r_rsp_data;
  - everything to 0.
  - Reset mid-operation discards all entries and pending responses.
- Ring occupancy:
  - occ = {wrap, top} - {wrap, bottom}, range 0..SRB_DEPTH.
  - full when occ == SRB_DEPTH.
  - w_req_ready = !full, combinational, independent of w_req_valid.
- Write: on w_req_valid & w_req_ready:
  - mem[top] <= w_req_data;
  - entry_valid[top] <= 1;
  - top increments modulo SRB_DEPTH and toggles the wrap bit on wrap.
  - w_rsp_idx is valid in the same cycle as the accept.
- Read channel c:
  - r_req_ready[c] = (!r_rsp_valid[c] | r_rsp_ready[c]) & !lost_arb[c].
  - On accept, the response registers load next cycle (latency 1). Back-to-back accepts at full throughput are allowed.
  - If entry_valid[idx] = 1: data = mem[idx], err = 0, and entry_valid[idx] <= 0.
  - If entry_valid[idx] = 0: data = 0, err = 1, and no state change.
  - The response holds stable while r_rsp_valid & !r_rsp_ready.
- Arbitration: if two or more channels request the same idx in one cycle, the lowest channel number wins and lost_arb is set for the others. Their r_req_ready is low that cycle, so they retry.
- Same-cycle write and read of the same idx: the read sees the pre-write entry_valid (0) and returns err. The write completes normally.
- Reclaim:
  - Each cycle, if occ != 0 and entry_valid[bottom] == 0, bottom increments by 1 (at most one slot per cycle).
  - Out-of-order frees leave holes until bottom reaches them.
  - Reclaim uses registered entry_valid, so a slot freed in cycle N is reclaimable from cycle N+1.
- Full-plus-free: a write is blocked in a cycle where full is true, even if a read frees an entry in that same cycle. Space becomes available only after bottom advances.
- bottom_id equals bottom; when empty, bottom_id == top.

Optional Feature:
- Macro: SRB_PEEK_EN.
- Defined: adds input r_req_peek [NUM_RD]. An accepted read with peek=1 returns data without clearing entry_valid. Same-idx arbitration still applies.
- Undefined: the port does not exist, and every successful read frees its entry.

Test Plan:
- Reset, then 8 writes of 0x11..0x88 with no reads -> w_rsp_idx 0..7; w_req_ready low after the 8th; entry_valid = 0xFF; bottom_id = 0.
- Full buffer; ch0 reads idx 0 -> next cycle r_rsp_valid[0]=1, data 0x11, err 0; entry_valid[0]=0; bottom_id = 1 one cycle later; w_req_ready goes high.
- Out of order: ch1 reads idx 3 then ch0 reads idx 1 -> bottom stays 1 until idx 1 freed, then advances 1->2; idx 2 still valid so it stops at 2.
- Ch0 and ch1 request idx 5 together -> ch0 gets 0x66; r_req_ready[1]=0 that cycle; ch1's retry next cycle returns err=1, data=0.
- Ch0 holds r_rsp_ready=0 for 3 cycles after a response -> data stable; r_req_ready[0]=0 throughout; ch1 continues at 1 read/cycle.
- rst_n low for 1 cycle with 4 entries and responses pending -> entry_valid=0, r_rsp_valid=0, bottom_id=0, w_rsp_idx=0 on the next cycle.

Source files
------------

// File: rtl/srb_mrd.sv
// Multi-read store result buffer: in-order allocation ring with NUM_RD indexed read channels.
// Optional macro SRB_PEEK_EN adds r_req_peek (read without freeing the entry).
module srb_mrd #(
    parameter int DATA_WIDTH = 32,
    parameter int SRB_DEPTH  = 8,
    parameter int NUM_RD     = 2,
    parameter int IDX_W      = $clog2(SRB_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         w_req_valid,
    output logic                         w_req_ready,
    input  logic [DATA_WIDTH-1:0]        w_req_data,
    output logic [IDX_W-1:0]             w_rsp_idx,
    input  logic [NUM_RD-1:0]            r_req_valid,
    input  logic [NUM_RD*IDX_W-1:0]      r_req_idx,
`ifdef SRB_PEEK_EN
    input  logic [NUM_RD-1:0]            r_req_peek,
`endif
    output logic [NUM_RD-1:0]            r_req_ready,
    output logic [NUM_RD-1:0]            r_rsp_valid,
    output logic [NUM_RD*DATA_WIDTH-1:0] r_rsp_data,
    output logic [NUM_RD-1:0]            r_rsp_err,
    input  logic [NUM_RD-1:0]            r_rsp_ready,
    output logic [SRB_DEPTH-1:0]         entry_valid,
    output logic [IDX_W-1:0]             bottom_id
);

    // Pointers carry one extra MSB acting as the wrap bit.
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(SRB_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q      [SRB_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d      [SRB_DEPTH];
    logic [SRB_DEPTH-1:0]  ev_q, ev_d;
    logic [PTR_W-1:0]      top_q, top_d;
    logic [PTR_W-1:0]      bot_q, bot_d;
    logic [PTR_W-1:0]      occ;
    logic                  full;
    logic                  wr_acc;

    logic [NUM_RD-1:0]     rsp_vld_q, rsp_vld_d;
    logic [NUM_RD-1:0]     rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_data_q [NUM_RD];
    logic [DATA_WIDTH-1:0] rsp_data_d [NUM_RD];

    logic [IDX_W-1:0]      rd_idx     [NUM_RD];
    logic [NUM_RD-1:0]     lost_arb;
    logic [NUM_RD-1:0]     rd_acc;
    logic [NUM_RD-1:0]     rd_peek;

`ifdef SRB_PEEK_EN
    assign rd_peek = r_req_peek;
`else
    assign rd_peek = '0;
`endif

    assign occ         = top_q - bot_q;
    assign full        = (occ == DEPTH_P);
    assign w_req_ready = !full;
    assign wr_acc      = w_req_valid && !full;
    assign w_rsp_idx   = top_q[IDX_W-1:0];
    assign bottom_id   = bot_q[IDX_W-1:0];
    assign entry_valid = ev_q;
    assign r_rsp_valid = rsp_vld_q;
    assign r_rsp_err   = rsp_err_q;

    always_comb begin
        for (int c = 0; c < NUM_RD; c++) begin
            rd_idx[c] = r_req_idx[c*IDX_W +: IDX_W];
        end
    end

    // Same-index collisions: the lowest-numbered requesting channel wins.
    always_comb begin
        lost_arb = '0;
        for (int c = 1; c < NUM_RD; c++) begin
            for (int p = 0; p < c; p++) begin
                if (r_req_valid[p] && r_req_valid[c] && (rd_idx[p] == rd_idx[c])) begin
                    lost_arb[c] = 1'b1;
                end
            end
        end
    end

    assign r_req_ready = (~rsp_vld_q | r_rsp_ready) & ~lost_arb;
    assign rd_acc      = r_req_valid & r_req_ready;

    always_comb begin
        for (int c = 0; c < NUM_RD; c++) begin
            r_rsp_data[c*DATA_WIDTH +: DATA_WIDTH] = rsp_data_q[c];
        end
    end

    always_comb begin
        mem_d      = mem_q;
        ev_d       = ev_q;
        top_d      = top_q;
        bot_d      = bot_q;
        rsp_vld_d  = rsp_vld_q;
        rsp_err_d  = rsp_err_q;
        rsp_data_d = rsp_data_q;

        // Reclaim looks only at registered flags, so a slot freed this cycle waits one cycle.
        if ((occ != '0) && !ev_q[bot_q[IDX_W-1:0]]) begin
            bot_d = bot_q + PTR_W'(1);
        end

        for (int c = 0; c < NUM_RD; c++) begin
            if (rd_acc[c]) begin
                rsp_vld_d[c] = 1'b1;
                if (ev_q[rd_idx[c]]) begin
                    rsp_data_d[c] = mem_q[rd_idx[c]];
                    rsp_err_d[c]  = 1'b0;
                    if (!rd_peek[c]) begin
                        ev_d[rd_idx[c]] = 1'b0;
                    end
                end else begin
                    rsp_data_d[c] = '0;
                    rsp_err_d[c]  = 1'b1;
                end
            end else if (r_rsp_ready[c]) begin
                rsp_vld_d[c] = 1'b0;
            end
        end

        // The top slot is never occupied when not full, so this cannot collide with a read clear.
        if (wr_acc) begin
            mem_d[top_q[IDX_W-1:0]] = w_req_data;
            ev_d[top_q[IDX_W-1:0]]  = 1'b1;
            top_d                   = top_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ev_q      <= '0;
            top_q     <= '0;
            bot_q     <= '0;
            rsp_vld_q <= '0;
            rsp_err_q <= '0;
            for (int i = 0; i < SRB_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            for (int c = 0; c < NUM_RD; c++) begin
                rsp_data_q[c] <= '0;
            end
        end else begin
            ev_q       <= ev_d;
            top_q      <= top_d;
            bot_q      <= bot_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_err_q  <= rsp_err_d;
            mem_q      <= mem_d;
            rsp_data_q <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_srb_mrd.sv
// Bench for srb_mrd: directed scenarios then random traffic against a counter/array reference model.
module tb_srb_mrd;
    localparam int DW = 32;
    localparam int D  = 8;
    localparam int NR = 2;
    localparam int IW = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              w_req_valid;
    logic              w_req_ready;
    logic [DW-1:0]     w_req_data;
    logic [IW-1:0]     w_rsp_idx;
    logic [NR-1:0]     r_req_valid;
    logic [NR*IW-1:0]  r_req_idx;
    logic [NR-1:0]     r_req_ready;
    logic [NR-1:0]     r_rsp_valid;
    logic [NR*DW-1:0]  r_rsp_data;
    logic [NR-1:0]     r_rsp_err;
    logic [NR-1:0]     r_rsp_ready;
    logic [D-1:0]      entry_valid;
    logic [IW-1:0]     bottom_id;
`ifdef SRB_PEEK_EN
    logic [NR-1:0]     r_req_peek = '0;
`endif

    always #5 clk = ~clk;

    srb_mrd #(.DATA_WIDTH(DW), .SRB_DEPTH(D), .NUM_RD(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .w_req_valid(w_req_valid), .w_req_ready(w_req_ready),
        .w_req_data(w_req_data), .w_rsp_idx(w_rsp_idx),
        .r_req_valid(r_req_valid), .r_req_idx(r_req_idx),
`ifdef SRB_PEEK_EN
        .r_req_peek(r_req_peek),
`endif
        .r_req_ready(r_req_ready), .r_rsp_valid(r_rsp_valid),
        .r_rsp_data(r_rsp_data), .r_rsp_err(r_rsp_err),
        .r_rsp_ready(r_rsp_ready), .entry_valid(entry_valid),
        .bottom_id(bottom_id)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain arrays plus unbounded allocation/reclaim counters.
    logic [DW-1:0] m_mem [D];
    bit            m_val [D];
    int            m_top, m_bot;
    bit            m_rv  [NR];
    bit            m_re  [NR];
    logic [DW-1:0] m_rd  [NR];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] ridx(input int c);
        return r_req_idx[c*IW +: IW];
    endfunction

    function automatic logic [DW-1:0] rdata(input int c);
        return r_rsp_data[c*DW +: DW];
    endfunction

    task automatic set_rd(input int c, input bit v, input int idx);
        r_req_valid[c]       = v;
        r_req_idx[c*IW +: IW] = idx[IW-1:0];
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) begin
            m_mem[i] = '0;
            m_val[i] = 1'b0;
        end
        for (int c = 0; c < NR; c++) begin
            m_rv[c] = 1'b0;
            m_re[c] = 1'b0;
            m_rd[c] = '0;
        end
        m_top = 0;
        m_bot = 0;
    endtask

    task automatic check_state(input string pfx);
        logic [D-1:0] ev;
        for (int i = 0; i < D; i++) ev[i] = m_val[i];
        chk({pfx, "_widx"}, 64'(w_rsp_idx), 64'(m_top % D));
        chk({pfx, "_bottom"}, 64'(bottom_id), 64'(m_bot % D));
        chk({pfx, "_ev"}, 64'(entry_valid), 64'(ev));
        for (int c = 0; c < NR; c++) begin
            chk($sformatf("%s_rvld%0d", pfx, c), 64'(r_rsp_valid[c]), 64'(m_rv[c]));
            if (m_rv[c]) begin
                chk($sformatf("%s_rdata%0d", pfx, c), 64'(rdata(c)), 64'(m_rd[c]));
                chk($sformatf("%s_rerr%0d", pfx, c), 64'(r_rsp_err[c]), 64'(m_re[c]));
            end
        end
    endtask

    // Inputs are driven just after a posedge; this checks the handshakes, advances the
    // model by one clock, then checks the registered state.
    task automatic cycle(input string pfx);
        bit            wr_ok;
        bit [NR-1:0]   rdy;
        bit            lost;
        bit [D-1:0]    clr;
        int            n_bot;
        int            i;
        #1;
        wr_ok = (m_top - m_bot) < D;
        chk({pfx, "_wrdy"}, 64'(w_req_ready), 64'(wr_ok));
        for (int c = 0; c < NR; c++) begin
            lost = 1'b0;
            for (int p = 0; p < c; p++) begin
                if (r_req_valid[p] && r_req_valid[c] && ridx(p) == ridx(c)) lost = 1'b1;
            end
            rdy[c] = (!m_rv[c] || r_rsp_ready[c]) && !lost;
            chk($sformatf("%s_rrdy%0d", pfx, c), 64'(r_req_ready[c]), 64'(rdy[c]));
        end
        n_bot = m_bot;
        if ((m_top - m_bot) > 0 && !m_val[m_bot % D]) n_bot = m_bot + 1;
        clr = '0;
        for (int c = 0; c < NR; c++) begin
            if (r_req_valid[c] && rdy[c]) begin
                i = int'(ridx(c));
                m_rv[c] = 1'b1;
                if (m_val[i]) begin
                    m_rd[c] = m_mem[i];
                    m_re[c] = 1'b0;
                    clr[i]  = 1'b1;
                end else begin
                    m_rd[c] = '0;
                    m_re[c] = 1'b1;
                end
            end else if (r_rsp_ready[c]) begin
                m_rv[c] = 1'b0;
            end
        end
        for (int k = 0; k < D; k++) if (clr[k]) m_val[k] = 1'b0;
        if (w_req_valid && wr_ok) begin
            m_mem[m_top % D] = w_req_data;
            m_val[m_top % D] = 1'b1;
            m_top++;
        end
        m_bot = n_bot;
        @(posedge clk);
        #1;
        check_state(pfx);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        check_state("rst");
        chk("rst_data", 64'(r_rsp_data), 64'(0));
        chk("rst_err", 64'(r_rsp_err), 64'(0));
        chk("rst_wrdy", 64'(w_req_ready), 64'(1));
    endtask

    task automatic idle();
        w_req_valid = 1'b0;
        r_req_valid = '0;
    endtask

    initial begin
        int hold_idx [3];
        logic [DW-1:0] hold_val [3];
        hold_idx = '{2, 4, 7};
        hold_val = '{32'h33, 32'h55, 32'h88};

        rst_n       = 1'b0;
        w_req_valid = 1'b0;
        w_req_data  = '0;
        r_req_valid = '0;
        r_req_idx   = '0;
        r_rsp_ready = '1;
        model_reset();
        do_reset();

        // Fill the ring.
        for (int k = 0; k < D; k++) begin
            w_req_valid = 1'b1;
            w_req_data  = 32'h11 * (k + 1);
            #1;
            chk("fill_idx", 64'(w_rsp_idx), 64'(k));
            cycle("fill");
        end
        w_req_data = 32'h99;
        cycle("full_wr");
        idle();
        #1;
        chk("full_wrdy", 64'(w_req_ready), 64'(0));
        chk("full_ev", 64'(entry_valid), 64'(8'hFF));
        chk("full_bot", 64'(bottom_id), 64'(0));

        // Read idx 0 on a full buffer.
        set_rd(0, 1, 0);
        cycle("rd0");
        set_rd(0, 0, 0);
        chk("rd0_vld", 64'(r_rsp_valid[0]), 64'(1));
        chk("rd0_data", 64'(rdata(0)), 64'(32'h11));
        chk("rd0_err", 64'(r_rsp_err[0]), 64'(0));
        chk("rd0_ev0", 64'(entry_valid[0]), 64'(0));
        chk("rd0_bot_same", 64'(bottom_id), 64'(0));
        cycle("rd0b");
        chk("rd0_bot1", 64'(bottom_id), 64'(1));
        chk("rd0_wrdy", 64'(w_req_ready), 64'(1));

        // Out-of-order frees.
        set_rd(1, 1, 3);
        cycle("ooo3");
        set_rd(1, 0, 0);
        cycle("ooo_w1");
        cycle("ooo_w2");
        chk("ooo_bot_hold", 64'(bottom_id), 64'(1));
        set_rd(0, 1, 1);
        cycle("ooo1");
        set_rd(0, 0, 0);
        chk("ooo_bot_still1", 64'(bottom_id), 64'(1));
        cycle("ooo_a");
        chk("ooo_bot2", 64'(bottom_id), 64'(2));
        cycle("ooo_b");
        chk("ooo_bot_stop", 64'(bottom_id), 64'(2));

        // Same-index collision.
        set_rd(0, 1, 5);
        set_rd(1, 1, 5);
        #1;
        chk("arb_rdy0", 64'(r_req_ready[0]), 64'(1));
        chk("arb_rdy1", 64'(r_req_ready[1]), 64'(0));
        cycle("arb");
        chk("arb_data0", 64'(rdata(0)), 64'(32'h66));
        set_rd(0, 0, 0);
        cycle("arb_retry");
        chk("retry_vld1", 64'(r_rsp_valid[1]), 64'(1));
        chk("retry_err1", 64'(r_rsp_err[1]), 64'(1));
        chk("retry_data1", 64'(rdata(1)), 64'(0));
        set_rd(1, 0, 0);

        // Channel 0 back-pressure while channel 1 streams.
        set_rd(0, 1, 6);
        r_rsp_ready[0] = 1'b0;
        cycle("hold_rd");
        set_rd(0, 0, 0);
        chk("hold_data0", 64'(rdata(0)), 64'(32'h77));
        for (int k = 0; k < 3; k++) begin
            set_rd(1, 1, hold_idx[k]);
            #1;
            chk("hold_rdy0", 64'(r_req_ready[0]), 64'(0));
            chk("hold_rdy1", 64'(r_req_ready[1]), 64'(1));
            cycle("hold");
            chk("hold_stable0", 64'(rdata(0)), 64'(32'h77));
            chk("hold_vld0", 64'(r_rsp_valid[0]), 64'(1));
            chk("hold_data1", 64'(rdata(1)), 64'(hold_val[k]));
        end
        r_rsp_ready[0] = 1'b1;
        idle();
        for (int k = 0; k < 6; k++) cycle("drain");

        // Reset with entries and responses pending.
        for (int k = 0; k < 4; k++) begin
            w_req_valid = 1'b1;
            w_req_data  = $urandom;
            cycle("pre_rst_wr");
        end
        w_req_valid = 1'b0;
        r_rsp_ready = '0;
        set_rd(0, 1, (m_bot % D));
        set_rd(1, 1, ((m_bot + 1) % D));
        cycle("pre_rst_rd");
        idle();
        do_reset();
        r_rsp_ready = '1;

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            w_req_valid = ($urandom_range(0, 99) < 55);
            w_req_data  = $urandom;
            for (int c = 0; c < NR; c++) begin
                set_rd(c, ($urandom_range(0, 99) < 60), int'($urandom_range(0, D - 1)));
                r_rsp_ready[c] = ($urandom_range(0, 99) < 75);
            end
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
